// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between four requesters, the shared downstream port and the arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          req;
    logic [4*DATA_W-1:0] din;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                busy;

    modport master (
        output req, din, out_ready,
        input  out_valid, out_data, gnt, sel, busy
    );

    modport slave (
        input  req, din, out_ready,
        output out_valid, out_data, gnt, sel, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux among four requesters and forwards the
// granted requester's beats to a single valid/ready sink, releasing on drop or MAX_HOLD beats.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int                CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         sel_r;
    logic [3:0]         gnt_r;
    logic [1:0]         ptr_r;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic [1:0]         pick_s;
    logic               req_sel_s;
    logic               accept_s;
    logic               release_s;
    logic               out_valid_s;
    logic [DATA_W-1:0]  out_data_s;
    logic               busy_s;

    // First asserted request scanning upward from the pointer, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr_v;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_v + 2'(k);
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [DATA_W-1:0] word_at(input logic [4*DATA_W-1:0] d, input logic [1:0] i);
        logic [DATA_W-1:0] w;
        case (i)
            2'd0:    w = d[0*DATA_W +: DATA_W];
            2'd1:    w = d[1*DATA_W +: DATA_W];
            2'd2:    w = d[2*DATA_W +: DATA_W];
            2'd3:    w = d[3*DATA_W +: DATA_W];
            default: w = d[0*DATA_W +: DATA_W];
        endcase
        return w;
    endfunction

    assign pick_s    = rr_pick(bus.req, ptr_r);
    assign req_sel_s = bus.req[sel_r];
    assign accept_s  = (state_r == GRANT) && req_sel_s && bus.out_ready;
    // A dropped request releases immediately; otherwise the MAX_HOLD-th accepted beat does.
    assign release_s = (state_r == GRANT) && (!req_sel_s || (accept_s && (beat_cnt_r == LAST_BEAT)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant, select, round-robin pointer and beat counter; sel is kept across release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r      <= 2'd0;
            gnt_r      <= 4'b0000;
            ptr_r      <= 2'd0;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req != 4'b0000) begin
                        sel_r      <= pick_s;
                        gnt_r      <= 4'b0001 << pick_s;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        gnt_r      <= 4'b0000;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        ptr_r      <= sel_r + 2'd1;
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    gnt_r      <= 4'b0000;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode: the data path stays combinational so out_data follows din.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = word_at(bus.din, 2'd0);
        busy_s      = 1'b0;
        case (state_r)
            IDLE: begin
                out_valid_s = 1'b0;
                out_data_s  = word_at(bus.din, 2'd0);
                busy_s      = 1'b0;
            end
            GRANT: begin
                out_valid_s = req_sel_s;
                out_data_s  = word_at(bus.din, sel_r);
                busy_s      = 1'b1;
            end
            default: begin
                out_valid_s = 1'b0;
                out_data_s  = word_at(bus.din, 2'd0);
                busy_s      = 1'b0;
            end
        endcase
    end

    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.busy      = busy_s;
    assign bus.gnt       = gnt_r;
    assign bus.sel       = sel_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized traffic, all checked each
// cycle against an integer-level reference model of the arbitration rules.
module tb_mux4_rr_arbiter;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    mux4_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept as plain integers.
    bit m_busy  = 1'b0;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    // Observed grant history: requester index per grant and beats accepted during it.
    int  grant_q[$];
    int  beats_q[$];
    bit  prev_busy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_of(input logic [4*DATA_W-1:0] d, input int i);
        return d[i*DATA_W +: DATA_W];
    endfunction

    function automatic int grant_at(input int i);
        if (i < grant_q.size()) return grant_q[i];
        else return -1;
    endfunction

    function automatic int beats_at(input int i);
        if (i < beats_q.size()) return beats_q[i];
        else return -1;
    endfunction

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [3:0]        e_gnt;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        bit                found;
        int                j;
        #2;
        e_gnt   = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        e_valid = m_busy && bus.req[m_sel];
        e_data  = m_busy ? word_of(bus.din, m_sel) : word_of(bus.din, 0);
        check_val("gnt", 32'(bus.gnt), 32'(e_gnt));
        check_val("sel", 32'(bus.sel), 32'(m_sel));
        check_val("busy", 32'(bus.busy), 32'(m_busy));
        check_val("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check_val("out_data", 32'(bus.out_data), 32'(e_data));
        check_val("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);

        if (bus.gnt != 4'b0000 && !prev_busy) begin
            grant_q.push_back(int'(bus.sel));
            beats_q.push_back(0);
        end
        if (!rst && bus.out_valid && bus.out_ready && beats_q.size() > 0)
            beats_q[beats_q.size()-1] = beats_q[beats_q.size()-1] + 1;
        prev_busy = (bus.gnt != 4'b0000);

        if (rst) begin
            m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!found && bus.req[j]) begin
                    found = 1'b1; m_busy = 1'b1; m_sel = j; m_beats = 0;
                end
            end
        end else if (!bus.req[m_sel]) begin
            m_busy = 1'b0; m_ptr = (m_sel + 1) % 4; m_beats = 0;
        end else if (bus.out_ready) begin
            m_beats++;
            if (m_beats == MAX_HOLD) begin
                m_busy = 1'b0; m_ptr = (m_sel + 1) % 4; m_beats = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        grant_q.delete();
        beats_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_log();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 4'hF;
        bus.din       = 32'h44332211;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // T1: reset held two cycles with all requests up, first grant to requester 0
        cycle();
        cycle();
        rst = 1'b0;
        clear_log();
        cycle();
        cycle();
        check_val("t1_first_grant", 32'(grant_at(0)), 32'd0);

        // T2: lone requester 2 gets four beats, one idle cycle, then again
        reset_dut();
        bus.req = 4'b0100;
        bus.din = {8'h00, 8'hA5, 8'h00, 8'h00};
        for (int c = 0; c < 12; c++) cycle();
        check_val("t2_grant0", 32'(grant_at(0)), 32'd2);
        check_val("t2_beats0", 32'(beats_at(0)), 32'd4);
        check_val("t2_grant1", 32'(grant_at(1)), 32'd2);

        // T3: all requesting, round-robin 0,1,2,3,0 with four beats each
        reset_dut();
        bus.req = 4'hF;
        bus.din = 32'hD4C3B2A1;
        for (int c = 0; c < 26; c++) cycle();
        for (int g = 0; g < 5; g++) begin
            check_val("t3_order", 32'(grant_at(g)), 32'(g % 4));
            check_val("t3_beats", 32'(beats_at(g)), 32'd4);
        end

        // T4: requester 1 drops after two beats, next grant goes to 2
        reset_dut();
        bus.req = 4'b0010;
        cycle();
        cycle();
        cycle();
        bus.req = 4'b0100;
        for (int c = 0; c < 4; c++) cycle();
        check_val("t4_grant0", 32'(grant_at(0)), 32'd1);
        check_val("t4_beats0", 32'(beats_at(0)), 32'd2);
        check_val("t4_grant1", 32'(grant_at(1)), 32'd2);

        // T5: backpressure on requester 3, data tracks din while stalled
        reset_dut();
        bus.req       = 4'b1000;
        bus.out_ready = 1'b0;
        cycle();
        for (int c = 0; c < 5; c++) begin
            bus.din = $urandom;
            cycle();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.din = $urandom;
            cycle();
        end
        check_val("t5_grant0", 32'(grant_at(0)), 32'd3);
        check_val("t5_beats0", 32'(beats_at(0)), 32'd4);

        // T6: reset after two beats of requester 0, then 0 is re-granted first
        reset_dut();
        bus.req = 4'b0001;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_log();
        bus.req = 4'b0011;
        for (int c = 0; c < 4; c++) cycle();
        check_val("t6_regrant", 32'(grant_at(0)), 32'd0);

        // Randomized traffic with occasional reset
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req[$urandom_range(0, 3)] = ~bus.req[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.din       = $urandom;
            rst           = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
